// File: rtl/onehot_decode_pipe.sv
// onehot_decode_pipe: registered select decoder (one-hot / thermometer)
// behind a 2-entry skid buffer with a valid/ready handshake on both sides.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    upstream handshake (in_ready is registered)
//   in_sel, in_mode      select value, 0 = one-hot / 1 = thermometer
//   out_valid/out_ready  downstream handshake
//   out_vec, out_err     decoded vector, select-out-of-range flag
module onehot_decode_pipe #(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_vec,
    output logic               out_err
);

    if (SEL_W < 1 || SEL_W > 6 ||
        NUM_OUT < 2 || NUM_OUT > (1 << SEL_W)) begin : g_param_chk
        $error("onehot_decode_pipe: illegal SEL_W/NUM_OUT");
    end

    logic [NUM_OUT-1:0] ent_vec_q [2];
    logic [1:0]         ent_err_q;
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [1:0]         count_q;
    logic [1:0]         count_d;
    logic               in_ready_q;

    logic               push;
    logic               pop;
    logic [NUM_OUT-1:0] dec_vec;
    logic               dec_err;
    int unsigned        sel_u;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    // Decode happens at accept time so the buffer holds final strobes.
    always_comb begin
        sel_u   = 32'(in_sel);
        dec_vec = '0;
        dec_err = 1'b0;
        if (sel_u >= NUM_OUT) begin
            dec_err = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                if (in_mode) begin
                    dec_vec[i] = (i <= sel_u);
                end else begin
                    dec_vec[i] = (i == sel_u);
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vec_q[0] <= '0;
            ent_vec_q[1] <= '0;
            ent_err_q    <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            in_ready_q   <= 1'b1;
        end else begin
            if (push) begin
                ent_vec_q[wr_ptr_q] <= dec_vec;
                ent_err_q[wr_ptr_q] <= dec_err;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_d;
            // Registered from next-count so upstream never sees a
            // combinational path from out_ready.
            in_ready_q <= (count_d < 2'd2);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_vec   = out_valid ? ent_vec_q[rd_ptr_q] : '0;
    assign out_err   = out_valid ? ent_err_q[rd_ptr_q] : 1'b0;

endmodule

// File: doc/onehot_decode_pipe.md
Name: onehot_decode_pipe

Overview:
- Parametrised, pipelined successor of the 2-to-4 select decoder: decodes a SEL_W-bit select into an NUM_OUT-bit one-hot or thermometer vector.
- Result is buffered behind a valid/ready handshake.
- Used to generate registered write-enable and lane-select strobes in the pipeline (register-file write port, bypass-lane select) without a combinational path from the select source.
- Contains a 2-entry skid buffer so upstream sees registered backpressure.

Parameters:
- SEL_W, 2, select width in bits; legal range 1..6.
- NUM_OUT, 4, decoded output width; legal range 2..2**SEL_W. Elaboration error outside this range.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has a select to decode
- in_ready  out  1  block can accept an input this cycle (registered)
- in_sel  in  SEL_W  select value
- in_mode  in  1  0 = one-hot, 1 = thermometer
- out_valid  out  1  out_vec / out_err valid
- out_ready  in  1  downstream accepts current output
- out_vec  out  NUM_OUT  decoded vector
- out_err  out  1  in_sel was >= NUM_OUT

Behaviour:
- Reset (rst_n low, asynchronous): count=0, rd_ptr=0, wr_ptr=0, in_ready=1, out_valid=0, out_vec=0, out_err=0. Entries are cleared.
- Reset mid-operation discards all buffered entries. After rst_n deasserts, the first accept is possible on the next rising edge.
- Accept: in_valid && in_ready on a rising edge.
  - Decoded result is written into entry wr_ptr; wr_ptr toggles.
- Decode (performed at accept, stored pre-decoded):
  - One-hot mode: out_vec[i] = (i == in_sel).
  - Thermometer mode: out_vec[i] = (i <= in_sel).
  - Out of range (in_sel >= NUM_OUT), either mode: out_vec = 0, out_err = 1.
  - Otherwise out_err = 0.
- Pop: out_valid && out_ready on a rising edge; rd_ptr toggles.
- Count update:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged
- Flags:
  - in_ready = (count < 2), registered from next-count. Push with count==2 is impossible.
  - out_valid = (count > 0).
  - out_vec / out_err always show entry rd_ptr, and are 0 when count==0.
- Latency: accept on edge N gives out_valid=1 with the result after edge N. Minimum 1 cycle, no combinational path from in_* to out_*.
- Throughput: 1 result per cycle when out_ready is held high.
- Backpressure: with out_ready low, two accepts fill the buffer and in_ready drops after the second accept edge.
  - The first pop with out_ready high re-asserts in_ready at the same edge, visible next cycle.
- Output stability: while out_valid=1 and out_ready=0, out_vec and out_err hold constant.
- Empty buffer: a simultaneous push with count==0 yields push-only behaviour. No bypass.
- Pointer wrap: single-bit pointers wrap 1 -> 0 naturally; ordering is strictly FIFO.
- in_sel and in_mode are ignored when in_valid=0 or in_ready=0.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with count=2 -> out_valid=0, out_vec=0, in_ready=1 immediately; first output after release equals the first new input.
- One-hot sweep, defaults, out_ready=1: in_sel=0,1,2,3 on consecutive cycles, mode 0 -> out_vec=0001,0010,0100,1000 one cycle later, back-to-back, out_err=0.
- Thermometer: in_sel=2, mode 1 -> out_vec=0111. Then in_sel=0 -> out_vec=0001.
- Out of range: SEL_W=3, NUM_OUT=5, in_sel=6 -> out_vec=00000, out_err=1. in_sel=4, mode 1 -> out_vec=11111, out_err=0.
- Backpressure: out_ready=0, push sel=1 then sel=3 -> in_ready=0 after the second edge, third input held off, out_vec stays 0010. Raise out_ready -> 0010 then 1000 in order, in_ready=1 after the first pop.
- Simultaneous push/pop at count=1 with out_ready toggling randomly for 1000 cycles -> scoreboard matches a reference FIFO, no drops or duplicates, count never exceeds 2.
